opt1_acc_drain: RTL
===================

OPT1_ACC_DRAIN -- requirements
Module: opt1_acc_drain

Interface
REQ-001 Parameter ACC_WIDTH, default 32: width of the incoming carry-save accumulator pair.
REQ-002 Parameter OUT_WIDTH, default 8: width of the signed requantized result.
REQ-003 Parameter FIFO_DEPTH, default 4: output buffer entries; SHALL be a power of two, at least 2.
REQ-004 clk  input  1: single clock; all state SHALL update on its rising edge.
REQ-005 rst_n  input  1: reset, asynchronous, active-low.
REQ-006 in_valid  input  1: acc_sum/acc_carry hold a final accumulation this cycle.
REQ-007 acc_sum  input  ACC_WIDTH: sum word of the redundant accumulator.
REQ-008 acc_carry  input  ACC_WIDTH: carry word of the redundant accumulator.
REQ-009 shift_amt  input  5: right-shift amount, sampled with in_valid.
REQ-010 in_ready  output  1: a drain slot is available; upstream SHALL NOT assert in_valid while low.
REQ-011 out_valid  output  1: out_data/out_sat hold a valid entry.
REQ-012 out_ready  input  1: consumer accepts the entry.
REQ-013 out_data  output  OUT_WIDTH: signed requantized result.
REQ-014 out_sat  output  1: out_data was clamped.
REQ-015 ovf_err  output  1: sticky flag, set when in_valid arrives while in_ready is low.

Function
REQ-016 Stage 1 SHALL register res = (acc_sum + acc_carry) mod 2^ACC_WIDTH as a signed value, along with shift_amt and a valid bit.
REQ-017 Stage 2 SHALL compute, in ACC_WIDTH+1 signed bits, t = (res + (shift_amt>0 ? 2^(shift_amt-1) : 0)) >>> shift_amt, using an arithmetic shift (round half up).
  - If shift_amt >= ACC_WIDTH, t SHALL be 0 for res >= 0 and -1 otherwise, before rounding.
REQ-018 Stage 2 SHALL saturate t to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1] and set sat=1 iff clamping occurred.
REQ-019 Stage 2 SHALL write {sat, data} into the FIFO in the same cycle its valid bit is set.
REQ-020 Latency: an in_valid accepted at edge N with the FIFO empty SHALL produce out_valid=1 in the cycle following edge N+2.
REQ-021 The FIFO SHALL preserve order and present its head entry on out_data/out_sat whenever out_valid=1.
REQ-022 An entry SHALL pop on any rising edge where out_valid && out_ready.
REQ-023 in_ready SHALL be 1 iff (fifo_count + stage1_valid + stage2_valid) < FIFO_DEPTH, computed from registered state only.
REQ-024 A pop and a write in the same cycle SHALL leave fifo_count unchanged; the pointers SHALL wrap modulo FIFO_DEPTH.
REQ-025 in_valid while in_ready=0 SHALL set ovf_err; that input SHALL be discarded and the pipeline left unaltered.
REQ-026 out_valid SHALL NOT depend combinationally on out_ready, and out_data SHALL stay stable while out_valid && !out_ready.
REQ-027 A sustained throughput of one result per cycle SHALL be achieved while out_ready=1.
REQ-028 When out_valid=0, out_data SHALL hold its last value (don't-care for checking).

Reset
REQ-029 While rst_n=0 the block SHALL hold:
  - out_valid=0, out_data=0, out_sat=0, ovf_err=0;
  - stage valid bits 0;
  - FIFO pointers and count 0;
  - in_ready=1.
REQ-030 Reset asserted mid-operation SHALL discard all in-flight and buffered entries immediately; no entry SHALL emerge after release.
REQ-031 ovf_err SHALL clear only on reset.

Verification
REQ-032 Basic: acc_sum=100, acc_carry=28, shift_amt=2, out_ready=1 -> out_data=32, out_sat=0, out_valid rising 2 edges after acceptance.
REQ-033 Rounding: res=6, shift 2 -> 2; res=-6, shift 2 -> -1; res=5, shift 0 -> 5.
REQ-034 Saturation and wrap (OUT_WIDTH=8): acc_sum=0x7FFFFFF0, acc_carry=0x20, shift 0 -> out_data=-128, out_sat=1; res=1000, shift 2 -> 127, out_sat=1.
REQ-035 Backpressure: hold out_ready=0 and issue inputs each cycle while in_ready=1.
  - Exactly FIFO_DEPTH are accepted, then in_ready=0.
  - Releasing out_ready drains them in order, with in_ready returning 1 after the first pop.
REQ-036 Overflow: in_valid while in_ready=0 -> ovf_err=1 and held; the FIFO contents are unchanged.
REQ-037 Reset mid-stream: assert rst_n=0 with 3 entries buffered -> out_valid=0 and in_ready=1 during reset; no stale output after release.

Source files
------------

// File: rtl/opt1_acc_drain.sv
// Drains a carry-save accumulator pair: resolves sum+carry, applies a rounding
// arithmetic right shift, saturates to a narrow signed result and buffers it in
// a small FIFO. in_ready reserves a FIFO slot for every entry still in the
// two-stage pipeline, so a write never finds the buffer full.
module opt1_acc_drain #(
    parameter int unsigned ACC_WIDTH  = 32,
    parameter int unsigned OUT_WIDTH  = 8,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic [ACC_WIDTH-1:0] acc_sum,
    input  logic [ACC_WIDTH-1:0] acc_carry,
    input  logic [4:0]           shift_amt,
    output logic                 in_ready,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OUT_WIDTH-1:0] out_data,
    output logic                 out_sat,
    output logic                 ovf_err
);

    localparam int unsigned PtrW = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CntW = PtrW + 1;
    localparam int unsigned OccW = PtrW + 2;

    // Saturation bounds held in the ACC_WIDTH+1 bit working width.
    localparam logic signed [ACC_WIDTH:0] SatMax =
        $signed({{(ACC_WIDTH - OUT_WIDTH + 2){1'b0}}, {(OUT_WIDTH - 1){1'b1}}});
    localparam logic signed [ACC_WIDTH:0] SatMin = ~SatMax;
    localparam logic signed [ACC_WIDTH:0] One    = {{ACC_WIDTH{1'b0}}, 1'b1};

    // Stage 1 state
    logic                 s1_valid_q, s1_valid_d;
    logic [ACC_WIDTH-1:0] s1_res_q, s1_res_d;
    logic [4:0]           s1_shift_q, s1_shift_d;

    // Stage 2 state
    logic                 s2_valid_q, s2_valid_d;
    logic [OUT_WIDTH-1:0] s2_data_q, s2_data_d;
    logic                 s2_sat_q, s2_sat_d;

    // FIFO state
    logic [OUT_WIDTH:0]   mem_q [FIFO_DEPTH];
    logic [OUT_WIDTH:0]   mem_d [FIFO_DEPTH];
    logic [PtrW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]      count_q, count_d;
    logic                 ovf_err_q, ovf_err_d;

    // Stage 2 datapath
    logic signed [ACC_WIDTH:0] res_ext;
    logic signed [ACC_WIDTH:0] bias;
    logic signed [ACC_WIDTH:0] t;
    logic [OUT_WIDTH-1:0]      sat_data;
    logic                      sat_flag;

    logic [OccW-1:0] occ;
    logic            accept;
    logic            fifo_wr;
    logic            fifo_rd;

    // Handshake: occupancy counts pipeline entries so each has a reserved slot.
    always_comb begin
        occ       = OccW'(count_q) + OccW'(s1_valid_q) + OccW'(s2_valid_q);
        in_ready  = (occ < OccW'(FIFO_DEPTH));
        accept    = in_valid && in_ready;
        out_valid = (count_q != '0);
        fifo_wr   = s2_valid_q;
        fifo_rd   = out_valid && out_ready;
        out_data  = mem_q[rd_ptr_q][OUT_WIDTH-1:0];
        out_sat   = mem_q[rd_ptr_q][OUT_WIDTH];
        ovf_err   = ovf_err_q;
    end

    // Stage 1 next state: resolve the redundant pair on acceptance.
    always_comb begin
        s1_valid_d = accept;
        s1_res_d   = s1_res_q;
        s1_shift_d = s1_shift_q;
        if (accept) begin
            s1_res_d   = acc_sum + acc_carry;
            s1_shift_d = shift_amt;
        end
    end

    // Stage 2 arithmetic: round half up, arithmetic shift, then saturate.
    always_comb begin
        res_ext = $signed({s1_res_q[ACC_WIDTH-1], s1_res_q});
        bias    = '0;
        if (s1_shift_q != 5'd0) begin
            bias = One <<< (s1_shift_q - 5'd1);
        end
        // Shifts at or beyond the operand width collapse to the sign fill.
        if (32'(s1_shift_q) >= ACC_WIDTH) begin
            t = res_ext[ACC_WIDTH] ? '1 : '0;
        end else begin
            t = (res_ext + bias) >>> s1_shift_q;
        end
        sat_flag = 1'b0;
        sat_data = t[OUT_WIDTH-1:0];
        if (t > SatMax) begin
            sat_flag = 1'b1;
            sat_data = SatMax[OUT_WIDTH-1:0];
        end else if (t < SatMin) begin
            sat_flag = 1'b1;
            sat_data = SatMin[OUT_WIDTH-1:0];
        end
    end

    // Stage 2 next state: capture the requantized result.
    always_comb begin
        s2_valid_d = s1_valid_q;
        s2_data_d  = s2_data_q;
        s2_sat_d   = s2_sat_q;
        if (s1_valid_q) begin
            s2_data_d = sat_data;
            s2_sat_d  = sat_flag;
        end
    end

    // FIFO next state: write from stage 2, pop on handshake, sticky overflow.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (fifo_wr) begin
            mem_d[wr_ptr_q] = {s2_sat_q, s2_data_q};
            wr_ptr_d        = wr_ptr_q + PtrW'(1);
        end
        if (fifo_rd) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
        if (fifo_wr && !fifo_rd) begin
            count_d = count_q + CntW'(1);
        end else if (!fifo_wr && fifo_rd) begin
            count_d = count_q - CntW'(1);
        end
        ovf_err_d = ovf_err_q | (in_valid & ~in_ready);
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_res_q   <= '0;
            s1_shift_q <= '0;
            s2_valid_q <= 1'b0;
            s2_data_q  <= '0;
            s2_sat_q   <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            ovf_err_q  <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_res_q   <= s1_res_d;
            s1_shift_q <= s1_shift_d;
            s2_valid_q <= s2_valid_d;
            s2_data_q  <= s2_data_d;
            s2_sat_q   <= s2_sat_d;
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            ovf_err_q  <= ovf_err_d;
        end
    end

endmodule
